// File: rtl/conv_seq.sv
// conv_seq: time-multiplexed convolution window accumulator.
//   One combinational fma is shared by every tap. Each accepted beat folds
//   filter*conv_input into the accumulator. After N = KSIZE*KSIZE*CHANNELS
//   beats the sum is offered downstream over a valid/ready handshake.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   in_valid/in_ready input beat handshake (ready only while accumulating)
//   filter/conv_input operand pair for the current tap
//   bias              initial accumulator value (CONV_SEQ_BIAS_EN builds only)
//   out_valid/out_ready result handshake
//   conv_output       window sum, held while out_valid=1
// Build option: define CONV_SEQ_BIAS_EN to seed each window with bias.

// fma: combinational single-precision y = a + b*c, single rounding (RNE).
//   Subnormal inputs are read as signed zero and results below the normal
//   range flush to signed zero. Any NaN operand, inf*0 or inf-inf gives the
//   quiet NaN 7FC00000. PREC is the number of guard bits kept below the
//   product LSB during alignment (>= 2 keeps rounding exact).
module fma #(
  parameter int PREC   = 15,
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] c,
  output logic [DATA_W-1:0] y
);
  localparam int W = 49 + PREC;  // carry bit + 48-bit product + guard bits

  logic          sa, sp, bs, ss, rs, a_big, neg, stk, inc;
  logic [7:0]    xa, xb, xc;
  logic [23:0]   ma, mb, mc;
  logic [47:0]   mp, am, bm, smm;
  logic [W-1:0]  bx, sx, sum, norm;
  logic [W:0]    diff;
  logic [2*W-1:0] shw;
  logic [24:0]   mr;
  logic [22:0]   frac;
  logic          a_nan, b_nan, c_nan, a_inf, b_inf, c_inf, b_zero, c_zero, nan;
  int            ea, ep, be, se, d, p, e;

  always_comb begin
    sa = a[31];
    sp = b[31] ^ c[31];
    xa = a[30:23];
    xb = b[30:23];
    xc = c[30:23];
    ma = (xa == 8'd0) ? 24'd0 : {1'b1, a[22:0]};
    mb = (xb == 8'd0) ? 24'd0 : {1'b1, b[22:0]};
    mc = (xc == 8'd0) ? 24'd0 : {1'b1, c[22:0]};
    // Product and addend share the scale 2^(exp-127-46).
    mp = {24'd0, mb} * {24'd0, mc};
    am = {1'b0, ma, 23'd0};
    ea = int'(xa);
    ep = int'(xb) + int'(xc) - 127;
    // A zero operand never sets the alignment exponent.
    a_big = (mp == 48'd0) || ((am != 48'd0) && (ea >= ep));
    be  = a_big ? ea : ep;
    se  = a_big ? ep : ea;
    bs  = a_big ? sa : sp;
    ss  = a_big ? sp : sa;
    bm  = a_big ? am : mp;
    smm = a_big ? mp : am;
    d   = be - se;
    d   = ((d < 0) || (d > W)) ? W : d;
    bx  = {1'b0, bm, {PREC{1'b0}}};
    shw = {1'b0, smm, {PREC{1'b0}}, {W{1'b0}}} >> d;
    // Bits shifted out collapse into a sticky LSB.
    stk = |shw[W-1:0];
    sx  = shw[2*W-1:W] | {{(W-1){1'b0}}, stk};
    diff = (bs == ss) ? ({1'b0, bx} + {1'b0, sx}) : ({1'b0, bx} - {1'b0, sx});
    neg  = (bs != ss) && diff[W];
    sum  = neg ? ({W{1'b0}} - diff[W-1:0]) : diff[W-1:0];
    rs   = neg ? ss : bs;
    p = 0;
    for (int i = 0; i < W; i++) if (sum[i]) p = i;
    norm = sum << (W - 1 - p);
    inc  = norm[W-25] & ((|norm[W-26:0]) | norm[W-24]);
    mr   = {1'b0, norm[W-1 -: 24]} + {24'd0, inc};
    e    = be + p - 46 - PREC + (mr[24] ? 1 : 0);
    frac = mr[24] ? mr[23:1] : mr[22:0];

    a_nan  = (xa == 8'hFF) && (a[22:0] != 23'd0);
    b_nan  = (xb == 8'hFF) && (b[22:0] != 23'd0);
    c_nan  = (xc == 8'hFF) && (c[22:0] != 23'd0);
    a_inf  = (xa == 8'hFF) && (a[22:0] == 23'd0);
    b_inf  = (xb == 8'hFF) && (b[22:0] == 23'd0);
    c_inf  = (xc == 8'hFF) && (c[22:0] == 23'd0);
    b_zero = (xb == 8'd0);
    c_zero = (xc == 8'd0);
    nan = a_nan | b_nan | c_nan | (b_inf & c_zero) | (c_inf & b_zero) |
          ((b_inf | c_inf) & a_inf & (sa != sp));

    y = '0;
    if (nan)                y = 32'h7FC0_0000;
    else if (b_inf | c_inf) y = {sp, 8'hFF, 23'd0};
    else if (a_inf)         y = {sa, 8'hFF, 23'd0};
    else if (sum == '0)     y = {sa & sp, 31'd0};  // -0 only for (-0)+(-0)
    else if (e >= 255)      y = {rs, 8'hFF, 23'd0};
    else if (e <= 0)        y = {rs, 31'd0};
    else                    y = {rs, 8'(e), frac};
  end
endmodule

module conv_seq #(
  parameter int KSIZE    = 7,
  parameter int CHANNELS = 1,
  parameter int FMA_PREC = 15,
  parameter int DATA_W   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] filter,
  input  logic [DATA_W-1:0] conv_input,
  input  logic [DATA_W-1:0] bias,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] conv_output
);
  localparam int N  = KSIZE * KSIZE * CHANNELS;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {ACCUM, DONE} state_t;

  state_t            state, state_nxt;
  logic [CW-1:0]     cnt;
  logic [DATA_W-1:0] acc, init, acc_in, fma_y;
  logic              accept, last;

`ifdef CONV_SEQ_BIAS_EN
  assign init = bias;
`else
  logic unused_bias;
  assign unused_bias = ^bias;
  assign init        = '0;
`endif

  assign accept = in_valid && in_ready;
  assign last   = (cnt == CW'(N - 1));
  // First beat of a window starts from init, never from a stale acc.
  assign acc_in = (cnt == '0) ? init : acc;

  fma #(.PREC(FMA_PREC), .DATA_W(DATA_W)) u_fma (
    .a(acc_in), .b(filter), .c(conv_input), .y(fma_y)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ACCUM;
      cnt   <= '0;
      acc   <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        acc <= fma_y;
        cnt <= last ? '0 : cnt + CW'(1);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      ACCUM: begin
        in_ready = 1'b1;
        if (in_valid && last) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = ACCUM;
      end
      default: state_nxt = ACCUM;
    endcase
  end

  assign conv_output = acc;
endmodule

// File: tb/tb_conv_seq.sv
// tb_conv_seq: self-checking bench for conv_seq.
//   Unit 0: KSIZE=2, CHANNELS=1 (N=4). Unit 1: KSIZE=1, CHANNELS=3 (N=3).
//   Operands are small integers in float form, so every expected sum is exact
//   and comes from plain integer arithmetic converted to IEEE-754 bits.
//   Inputs change and outputs are sampled just after the falling edge.
module tb_conv_seq;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [1:0]       in_valid, in_ready, out_valid, out_ready;
  logic [1:0][31:0] filt, inp, bias, outp;
  int checks = 0, failures = 0;

`ifdef CONV_SEQ_BIAS_EN
  localparam bit BIAS_ON = 1'b1;
`else
  localparam bit BIAS_ON = 1'b0;
`endif

  conv_seq #(.KSIZE(2), .CHANNELS(1)) u_k2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .filter(filt[0]), .conv_input(inp[0]), .bias(bias[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .conv_output(outp[0])
  );

  conv_seq #(.KSIZE(1), .CHANNELS(3)) u_c3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .filter(filt[1]), .conv_input(inp[1]), .bias(bias[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .conv_output(outp[1])
  );

  // Integer -> IEEE-754 single bits (exact for |v| < 2^24).
  function automatic logic [31:0] i2f(input int v);
    int m, k;
    logic [31:0] mm;
    if (v == 0) return 32'h0;
    m = (v < 0) ? -v : v;
    k = 0;
    for (int i = 0; i < 31; i++) if (((m >> i) & 1) != 0) k = i;
    mm = 32'(m) << (23 - k);
    return {(v < 0), 8'(127 + k), mm[22:0]};
  endfunction

  function automatic int rnd(input int lo, input int hi);
    return lo + int'($urandom_range(hi - lo));
  endfunction

  // Present one beat and return once it has been accepted.
  task automatic beat(input int u, input logic [31:0] f, input logic [31:0] x);
    int guard;
    guard = 0;
    in_valid[u] = 1'b1; filt[u] = f; inp[u] = x;
    while (in_ready[u] !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (guard >= 20) begin
      failures++;
      $display("FAIL beat_accept unit=%0d in_ready=%b want 1", u, in_ready[u]);
    end
    @(negedge clk);
    in_valid[u] = 1'b0;
  endtask

  task automatic pop(input int u);
    out_ready[u] = 1'b1;
    @(negedge clk);
    out_ready[u] = 1'b0;
    checks++;
    if (out_valid[u] !== 1'b0 || in_ready[u] !== 1'b1) begin
      failures++;
      $display("FAIL pop_release unit=%0d out_valid=%b in_ready=%b want 0/1", u, out_valid[u], in_ready[u]);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int u = 0; u < 2; u++) begin
      checks++;
      if (out_valid[u] !== 1'b0) begin failures++; $display("FAIL reset_out_valid unit=%0d got %b want 0", u, out_valid[u]); end
      checks++;
      if (in_ready[u] !== 1'b1) begin failures++; $display("FAIL reset_in_ready unit=%0d got %b want 1", u, in_ready[u]); end
      checks++;
      if (outp[u] !== 32'h0) begin failures++; $display("FAIL reset_acc unit=%0d got %h want 00000000", u, outp[u]); end
    end
  endtask

  task automatic test_basic();
    logic [31:0] exp;
    exp = BIAS_ON ? 32'h4110_0000 : 32'h4100_0000;
    bias[0] = 32'h3F80_0000;
    for (int k = 1; k <= 4; k++) begin
      beat(0, 32'h3F80_0000, 32'h4000_0000);
      if (k == 3) begin
        checks++;
        if (out_valid[0] !== 1'b0) begin failures++; $display("FAIL basic_early_valid got %b want 0", out_valid[0]); end
      end
    end
    checks++;
    if (out_valid[0] !== 1'b1) begin failures++; $display("FAIL basic_out_valid got %b want 1", out_valid[0]); end
    checks++;
    if (in_ready[0] !== 1'b0) begin failures++; $display("FAIL basic_done_in_ready got %b want 0", in_ready[0]); end
    checks++;
    if (outp[0] !== exp) begin failures++; $display("FAIL basic_result got %h want %h", outp[0], exp); end
    pop(0);
  endtask

  task automatic test_gapped();
    int bv;
    bv = BIAS_ON ? 1 : 0;
    bias[0] = 32'h3F80_0000;
    for (int k = 1; k <= 4; k++) begin
      beat(0, 32'h3F80_0000, 32'h4000_0000);
      if (k < 4) begin
        @(negedge clk);
        checks++;
        if (outp[0] !== i2f(bv + 2 * k) || out_valid[0] !== 1'b0) begin
          failures++;
          $display("FAIL gap_hold beat=%0d acc=%h out_valid=%b want %h/0", k, outp[0], out_valid[0], i2f(bv + 2 * k));
        end
      end
    end
    checks++;
    if (out_valid[0] !== 1'b1 || outp[0] !== i2f(bv + 8)) begin
      failures++;
      $display("FAIL gap_result got %h valid=%b want %h", outp[0], out_valid[0], i2f(bv + 8));
    end
    pop(0);
  endtask

  task automatic test_backpressure();
    int bv;
    bv = BIAS_ON ? 1 : 0;
    bias[0] = 32'h3F80_0000;
    repeat (4) beat(0, 32'h3F80_0000, 32'h4000_0000);
    // New beat waits at the input the whole time the result is stalled.
    in_valid[0] = 1'b1; filt[0] = 32'h4040_0000; inp[0] = 32'h3F80_0000;
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      checks++;
      if (out_valid[0] !== 1'b1 || in_ready[0] !== 1'b0 || outp[0] !== i2f(bv + 8)) begin
        failures++;
        $display("FAIL stall_hold cycle=%0d valid=%b ready=%b out=%h want 1/0/%h", s, out_valid[0], in_ready[0], outp[0], i2f(bv + 8));
      end
    end
    pop(0);
    beat(0, 32'h4040_0000, 32'h3F80_0000);
    repeat (3) beat(0, 32'h3F80_0000, 32'h3F80_0000);
    checks++;
    if (out_valid[0] !== 1'b1 || outp[0] !== i2f(bv + 6)) begin
      failures++;
      $display("FAIL stall_next_window got %h valid=%b want %h", outp[0], out_valid[0], i2f(bv + 6));
    end
    pop(0);
  endtask

  task automatic test_reset_mid();
    logic [31:0] exp;
    exp = BIAS_ON ? 32'h40A0_0000 : 32'h4080_0000;
    bias[0] = 32'h3F80_0000;
    repeat (2) beat(0, 32'h4000_0000, 32'h4040_0000);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if (outp[0] !== 32'h0 || out_valid[0] !== 1'b0 || in_ready[0] !== 1'b1) begin
      failures++;
      $display("FAIL midreset_state out=%h valid=%b ready=%b want 0/0/1", outp[0], out_valid[0], in_ready[0]);
    end
    repeat (4) beat(0, 32'h3F80_0000, 32'h3F80_0000);
    checks++;
    if (out_valid[0] !== 1'b1 || outp[0] !== exp) begin
      failures++;
      $display("FAIL midreset_result got %h valid=%b want %h", outp[0], out_valid[0], exp);
    end
    // Reset while the result is pending drops it.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if (out_valid[0] !== 1'b0 || in_ready[0] !== 1'b1) begin
      failures++;
      $display("FAIL donereset_state valid=%b ready=%b want 0/1", out_valid[0], in_ready[0]);
    end
  endtask

  task automatic test_multi_channel();
    logic [31:0] exp;
    exp = BIAS_ON ? 32'h40E0_0000 : 32'h40C0_0000;
    bias[1] = 32'h3F80_0000;
    beat(1, 32'h3F80_0000, 32'h3F80_0000);
    beat(1, 32'h4000_0000, 32'h3F80_0000);
    checks++;
    if (out_valid[1] !== 1'b0) begin failures++; $display("FAIL mc_early_valid got %b want 0", out_valid[1]); end
    beat(1, 32'h4040_0000, 32'h3F80_0000);
    checks++;
    if (out_valid[1] !== 1'b1 || outp[1] !== exp) begin
      failures++;
      $display("FAIL mc_result got %h valid=%b want %h", outp[1], out_valid[1], exp);
    end
    pop(1);
  endtask

  task automatic test_random();
    int u, n, bi, fi, xi, sum, gaps, stalls;
    for (int w = 0; w < 24; w++) begin
      u  = w % 2;
      n  = (u == 0) ? 4 : 3;
      bi = rnd(-4, 4);
      bias[u] = i2f(bi);
      sum = BIAS_ON ? bi : 0;
      for (int k = 0; k < n; k++) begin
        fi = rnd(-8, 8);
        xi = rnd(-8, 8);
        beat(u, i2f(fi), i2f(xi));
        sum += fi * xi;
        if (k < n - 1) begin
          gaps = rnd(0, 2);
          repeat (gaps) @(negedge clk);
          checks++;
          if (outp[u] !== i2f(sum) || out_valid[u] !== 1'b0) begin
            failures++;
            $display("FAIL rand_partial w=%0d k=%0d got %h valid=%b want %h", w, k, outp[u], out_valid[u], i2f(sum));
          end
        end
      end
      checks++;
      if (out_valid[u] !== 1'b1 || outp[u] !== i2f(sum)) begin
        failures++;
        $display("FAIL rand_result w=%0d got %h valid=%b want %h", w, outp[u], out_valid[u], i2f(sum));
      end
      stalls = rnd(0, 3);
      in_valid[u] = 1'b1; filt[u] = $urandom; inp[u] = $urandom;
      for (int s = 0; s < stalls; s++) begin
        @(negedge clk);
        checks++;
        if (out_valid[u] !== 1'b1 || in_ready[u] !== 1'b0 || outp[u] !== i2f(sum)) begin
          failures++;
          $display("FAIL rand_stall w=%0d got %h valid=%b ready=%b want %h", w, outp[u], out_valid[u], in_ready[u], i2f(sum));
        end
      end
      in_valid[u] = 1'b0;
      pop(u);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = '0; out_ready = '0; filt = '0; inp = '0; bias = '0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_gapped();
    test_backpressure();
    test_reset_mid();
    test_multi_channel();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
